// File: rtl/ascon_serdes_if.sv
// rtl/ascon_serdes_if.sv - serial D-share loader and result unloader for the masked Ascon core
module ascon_serdes_if #(
  parameter int K = 128,
  parameter int L = 80,
  parameter int Y = 80,
  parameter int W = 1,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D*W-1:0]   key_in,
  input  logic [D*W-1:0]   nonce_in,
  input  logic [D*W-1:0]   ad_in,
  input  logic [D*W-1:0]   dat_in,
  input  logic             enc_start,
  input  logic             dec_start,
  output logic             armed,
  output logic [D*K-1:0]   core_key,
  output logic [D*128-1:0] core_nonce,
  output logic [D*L-1:0]   core_ad,
  output logic [D*Y-1:0]   core_dat,
  output logic             core_start,
  output logic             core_mode,
  input  logic             core_done,
  input  logic [Y-1:0]     core_res,
  input  logic [127:0]     core_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     res_out,
  output logic [W-1:0]     tag_out,
  output logic             out_last,
  output logic             done
);

  localparam int M1     = (K > 128) ? K : 128;
  localparam int M2     = (L > Y) ? L : Y;
  localparam int N_IN   = ((M1 > M2) ? M1 : M2) / W;
  localparam int N_OUT  = ((Y > 128) ? Y : 128) / W;
  localparam int CW_IN  = $clog2(N_IN + 1);
  localparam int CW_OUT = $clog2(N_OUT + 1);

  localparam logic [CW_IN-1:0]  NK_C    = CW_IN'(K / W);
  localparam logic [CW_IN-1:0]  NN_C    = CW_IN'(128 / W);
  localparam logic [CW_IN-1:0]  NL_C    = CW_IN'(L / W);
  localparam logic [CW_IN-1:0]  NY_C    = CW_IN'(Y / W);
  localparam logic [CW_IN-1:0]  IN_LAST = CW_IN'(N_IN - 1);
  localparam logic [CW_OUT-1:0] OUT_LAST = CW_OUT'(N_OUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_ARMED, S_BUSY, S_UNLOAD} state_t;

  state_t              state_q, state_d;
  logic [CW_IN-1:0]    in_cnt_q, in_cnt_d;
  logic [CW_OUT-1:0]   out_cnt_q, out_cnt_d;
  logic [D*K-1:0]      key_q, key_d;
  logic [D*128-1:0]    nonce_q, nonce_d;
  logic [D*L-1:0]      ad_q, ad_d;
  logic [D*Y-1:0]      dat_q, dat_d;
  logic [Y-1:0]        res_sr_q, res_sr_d;
  logic [127:0]        tag_sr_q, tag_sr_d;
  logic                core_start_q, core_start_d;
  logic                core_mode_q, core_mode_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    ad_d         = ad_q;
    dat_d        = dat_q;
    res_sr_d     = res_sr_q;
    tag_sr_d     = tag_sr_q;
    core_start_d = 1'b0;
    core_mode_d  = core_mode_q;
    done_d       = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          // Shorter fields freeze once full so the first beat stays in their MSBs.
          for (int s = 0; s < D; s++) begin
            if (in_cnt_q < NK_C)
              key_d[s*K +: K] = (key_q[s*K +: K] << W) | K'(key_in[s*W +: W]);
            if (in_cnt_q < NN_C)
              nonce_d[s*128 +: 128] = (nonce_q[s*128 +: 128] << W) | 128'(nonce_in[s*W +: W]);
            if (in_cnt_q < NL_C)
              ad_d[s*L +: L] = (ad_q[s*L +: L] << W) | L'(ad_in[s*W +: W]);
            if (in_cnt_q < NY_C)
              dat_d[s*Y +: Y] = (dat_q[s*Y +: Y] << W) | Y'(dat_in[s*W +: W]);
          end
          in_cnt_d = in_cnt_q + CW_IN'(1);
          if (in_cnt_q == IN_LAST)
            state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (enc_start || dec_start) begin
          core_start_d = 1'b1;
          core_mode_d  = !enc_start;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (core_done) begin
          res_sr_d = core_res;
          tag_sr_d = core_tag;
          state_d  = S_UNLOAD;
        end
      end
      default: begin
        if (out_ready) begin
          res_sr_d  = res_sr_q >> W;
          tag_sr_d  = tag_sr_q >> W;
          out_cnt_d = out_cnt_q + CW_OUT'(1);
          if (out_cnt_q == OUT_LAST) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            key_d     = '0;
            nonce_d   = '0;
            ad_d      = '0;
            dat_d     = '0;
            res_sr_d  = '0;
            tag_sr_d  = '0;
            done_d    = 1'b1;
            state_d   = S_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      key_q        <= '0;
      nonce_q      <= '0;
      ad_q         <= '0;
      dat_q        <= '0;
      res_sr_q     <= '0;
      tag_sr_q     <= '0;
      core_start_q <= 1'b0;
      core_mode_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ad_q         <= ad_d;
      dat_q        <= dat_d;
      res_sr_q     <= res_sr_d;
      tag_sr_q     <= tag_sr_d;
      core_start_q <= core_start_d;
      core_mode_q  <= core_mode_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign armed      = (state_q == S_ARMED);
  assign out_valid  = (state_q == S_UNLOAD);
  assign res_out    = out_valid ? res_sr_q[W-1:0] : '0;
  assign tag_out    = out_valid ? tag_sr_q[W-1:0] : '0;
  assign out_last   = out_valid && (out_cnt_q == OUT_LAST);
  assign core_key   = key_q;
  assign core_nonce = nonce_q;
  assign core_ad    = ad_q;
  assign core_dat   = dat_q;
  assign core_start = core_start_q;
  assign core_mode  = core_mode_q;
  assign done       = done_q;

endmodule

// File: doc/ascon_serdes_if.md
# ascon_serdes_if

Parameterised serial front-end for the masked Ascon AEAD core. It loads key, nonce, associated data and plaintext/ciphertext as D-share, W-bit-per-beat streams under valid/ready flow control, then arms and launches the core in encrypt or decrypt mode. When the core finishes, it captures the data result and tag and streams them out W bits per beat with backpressure. It sits between the chip-level pins or test harness and the core, and replaces fixed 1-bit, free-running shift loading.

## Interface
- K, 128: key length in bits
- L, 80: associated-data length in bits
- Y, 80: plaintext/ciphertext length in bits
- W, 1: bits per beat per share; K, 128, L and Y must all be multiples of W
- D, 3: number of masking shares (D ≥ 1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- key_in / nonce_in / ad_in / dat_in  in  D*W each  share s in bits [s*W +: W]
- enc_start / dec_start  in  1  command request; sampled only in ARMED
- armed  out  1  all fields loaded, waiting for a command
- core_key / core_nonce / core_ad / core_dat  out  D*K / D*128 / D*L / D*Y  parallel shares; share s in bits [s*len +: len]
- core_start  out  1  one-cycle launch pulse
- core_mode  out  1  0 = encrypt, 1 = decrypt; stable from core_start until the capture
- core_done  in  1  core result valid pulse
- core_res  in  Y  ciphertext (encrypt) or plaintext (decrypt)
- core_tag  in  128  tag
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid & out_ready
- res_out / tag_out  out  W each  current output beat
- out_last  out  1  high on the final output beat
- done  out  1  one-cycle pulse after the final output transfer

## Operation
- N_IN = max(K,128,L,Y)/W input beats; N_OUT = max(Y,128)/W output beats.
- FSM states: LOAD → ARMED → BUSY → UNLOAD → LOAD.
- **LOAD**
  - in_ready = 1.
  - Each accepted beat shifts every field share register left by W, with the new bits entering the LSBs.
  - A field stops shifting once it has taken len/W beats. The first beat therefore ends up in the MSBs of every field.
  - in_cnt counts accepted beats. The beat that makes in_cnt reach N_IN moves the FSM to ARMED.
- **ARMED**
  - armed = 1.
  - enc_start or dec_start issues core_start (one cycle) with core_mode latched, and moves to BUSY.
  - If both are asserted together, encrypt wins.
- **BUSY**
  - Waits for core_done.
  - On core_done, captures core_res and core_tag into output shift registers and moves to UNLOAD.
- **UNLOAD**
  - out_valid = 1.
  - res_out = res_sr[W-1:0] and tag_out = tag_sr[W-1:0]: LSB-first, bit index j·W on beat j.
  - Each transfer shifts both registers right by W.
  - res_out reads 0 after Y/W beats; tag_out reads 0 after 128/W beats.
  - out_last = (out_cnt == N_OUT-1).
  - The final transfer clears all counters and field registers, pulses done, and returns to LOAD.
- Ignored events:
  - enc_start/dec_start outside ARMED.
  - core_done outside BUSY.
  - in_valid outside LOAD.
- Counters are $clog2(N+1) bits wide and never wrap. They can only be cleared by the state transition or by rst.
- Field registers hold their contents through ARMED, BUSY and UNLOAD. core_* field outputs equal the field registers at all times.

## Timing
- Reset values: in_ready = 1; armed, core_start, core_mode, out_valid, out_last, done, res_out, tag_out all 0; state = LOAD; all registers 0.
- rst in any state, including mid-load or mid-unload, returns to reset values on the next edge.
- in_ready, armed, out_valid, res_out, tag_out and out_last are decoded from registered state. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Last input beat accepted at edge t → armed high from t+1.
- Command sampled at edge t → core_start high for cycle t+1 only; state is BUSY from t+1.
- core_done sampled at edge t → out_valid high with beat 0 from t+1.
- Full-rate streaming: N_IN beats in N_IN cycles, N_OUT beats in N_OUT cycles.
- Output stall (out_ready = 0) holds res_out, tag_out and out_last unchanged.
- done is high in the cycle after the last transfer, coincident with in_ready = 1.

## Test plan
- **Defaults, W=1:** stream key=0x000102…0F, nonce=0x10…1F, AD=0xA5×10, PT=0x3C×10 with share1 = share2 = random and share0 XOR-masked → core_key share recombination = key; armed after exactly 128 beats.
- **W=8, D=2, K=128, L=Y=64:** 16 beats → armed; enc_start → core_start one cycle with core_mode = 0. Drive core_done with core_res=0x0123456789ABCDEF and tag=0xFF…00 → res_out beats 0xEF, 0xCD, …, 0x01 then 0x00; tag_out LSB byte first; out_last on beat 15.
- **Backpressure and input gaps:** random in_valid gaps and out_ready deasserted 3 cycles mid-stream → identical register contents and output sequence to the gap-free run; output held stable while stalled.
- **Command rules:** enc_start during LOAD and core_done during ARMED → ignored. enc_start and dec_start asserted together → core_mode = 0.
- **Decrypt:** dec_start → core_mode = 1; after core_done, out_valid follows on the next cycle.
- **Reset mid-operation:** rst during UNLOAD beat 5 → out_valid = 0 and in_ready = 1 next cycle. A full second message then loads and completes correctly with done pulsed once.
